divu_seq: RTL

Sequential 32-bit unsigned divider, the inverse of the existing combinational unsigned multiplier. It computes quotient and remainder with a restoring shift-subtract algorithm that retires one quotient bit per clock. It sits beside the multiplier in the execute stage and feeds the HI/LO registers for DIVU. It uses a start/busy/done handshake, so the pipeline stalls while `busy` is high.

---
 rtl/divu_seq_if.sv | 23 ++
 rtl/divu_seq.sv | 124 ++++++++++++
 2 files changed

// File: rtl/divu_seq_if.sv
// Request/result bundle for the sequential unsigned divider.
// The requester drives start and the operands. The divider returns the result and status.
// Clock and reset are not part of the bundle and stay plain ports on the divider.
interface divu_seq_if;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] q;
  logic [31:0] r;
  logic        busy;
  logic        done;
  logic        div_zero;

  modport master (
    output start, dividend, divisor,
    input  q, r, busy, done, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output q, r, busy, done, div_zero
  );
endinterface

// File: rtl/divu_seq.sv
// Sequential 32-bit unsigned restoring divider; quotient in q (LO), remainder in r (HI).
// Latency: 32 cycles from accepting start to the result; a zero divisor completes on the accepting edge.
// Backpressure: start is ignored while busy is high; a start during the done cycle is accepted back-to-back.
module divu_seq (
  input  logic      clk,
  input  logic      rst_n,
  divu_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] pr_q, pr_d;     // partial remainder, always < divisor so 32 bits suffice
  logic [31:0] wq_q, wq_d;     // dividend shifting out, quotient bits shifting in
  logic [31:0] dvs_q, dvs_d;   // latched divisor
  logic [31:0] q_q, q_d;
  logic [31:0] r_q, r_d;
  logic        dz_q, dz_d;

  logic [32:0] pr_sh;
  logic [32:0] trial;
  logic [31:0] pr_step;
  logic [31:0] wq_step;
  logic        accept;

  // Start is honoured in IDLE and DONE, never while a division is running
  assign accept = bus.start && (state_q != RUN);

  // One restoring step: shift in the next dividend bit, trial-subtract, keep or restore
  always_comb begin
    pr_sh = {pr_q, wq_q[31]};
    trial = pr_sh - {1'b0, dvs_q};
    if (!trial[32]) begin
      pr_step = trial[31:0];
      wq_step = {wq_q[30:0], 1'b1};
    end else begin
      pr_step = pr_sh[31:0];
      wq_step = {wq_q[30:0], 1'b0};
    end
  end

  // Next-state and datapath updates for the IDLE/RUN/DONE controller
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pr_d    = pr_q;
    wq_d    = wq_q;
    dvs_d   = dvs_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (bus.divisor == 32'd0) begin
            // Zero divisor: skip RUN, publish the saturated result on the accepting edge
            state_d = DONE;
            q_d     = 32'hFFFF_FFFF;
            r_d     = bus.dividend;
            dz_d    = 1'b1;
          end else begin
            state_d = RUN;
            dvs_d   = bus.divisor;
            pr_d    = 32'd0;
            wq_d    = bus.dividend;
            cnt_d   = 5'd0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        pr_d  = pr_step;
        wq_d  = wq_step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          q_d     = wq_step;
          r_d     = pr_step;
          dz_d    = 1'b0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Working and result registers; reset also aborts any division in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 5'd0;
      pr_q  <= 32'd0;
      wq_q  <= 32'd0;
      dvs_q <= 32'd0;
      q_q   <= 32'd0;
      r_q   <= 32'd0;
      dz_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pr_q  <= pr_d;
      wq_q  <= wq_d;
      dvs_q <= dvs_d;
      q_q   <= q_d;
      r_q   <= r_d;
      dz_q  <= dz_d;
    end
  end

  assign bus.q        = q_q;
  assign bus.r        = r_q;
  assign bus.div_zero = dz_q;
  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == DONE);

endmodule
